hazard_stall_unit: RTL and testbench

- Producer side of the EX-stage operand-bypass path. Carries the hazard-relevant fields of each instruction through ID/EX, EX/MEM and MEM/WB shadow registers; these registered fields feed the bypass-select logic.
- Detects load-use hazards that bypassing cannot cover and freezes PC and IF/ID while it injects bubbles. Also generates the IF/ID flush for taken branches.
- Sits beside the main pipeline registers and is clocked with them.

---
 rtl/hazard_stall_unit_if.sv | 42 ++++
 rtl/hazard_stall_unit.sv | 116 +++++++++++
 tb/tb_hazard_stall_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Bundle between the ID stage and the hazard/stall unit: ID-stage fields in,
// stall controls and shadow-register fields out.
interface hazard_stall_unit_if #(
  parameter int unsigned REG_W = 2,
  parameter int unsigned CNT_W = 8
);
  logic [REG_W-1:0] IFID_rs;
  logic [REG_W-1:0] IFID_rt;
  logic [REG_W-1:0] IFID_rd;
  logic             IFID_RegWrite;
  logic             IFID_MemRead;
  logic             IFID_valid;
  logic             branch_taken;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEX_bubble;
  logic [REG_W-1:0] IDEX_rs;
  logic [REG_W-1:0] IDEX_rt;
  logic [REG_W-1:0] IDEX_rd;
  logic             IDEX_RegWrite;
  logic             IDEX_MemRead;
  logic [REG_W-1:0] EXMEM_rd;
  logic             EXMEM_RegWrite;
  logic [REG_W-1:0] MEMWB_rd;
  logic             MEMWB_RegWrite;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output IFID_rs, IFID_rt, IFID_rd, IFID_RegWrite, IFID_MemRead, IFID_valid, branch_taken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEX_bubble,
    input  IDEX_rs, IDEX_rt, IDEX_rd, IDEX_RegWrite, IDEX_MemRead,
    input  EXMEM_rd, EXMEM_RegWrite, MEMWB_rd, MEMWB_RegWrite, stall_count
  );

  modport slave (
    input  IFID_rs, IFID_rt, IFID_rd, IFID_RegWrite, IFID_MemRead, IFID_valid, branch_taken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEX_bubble,
    output IDEX_rs, IDEX_rt, IDEX_rd, IDEX_RegWrite, IDEX_MemRead,
    output EXMEM_rd, EXMEM_RegWrite, MEMWB_rd, MEMWB_RegWrite, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection with multi-cycle bubble insertion, branch flush
// generation and ID/EX, EX/MEM, MEM/WB shadow registers for the bypass path.
module hazard_stall_unit #(
  parameter int unsigned REG_W        = 2,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave bus
);
  localparam int unsigned HOLD_W = 3;

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              hazard, stall;

  logic [REG_W-1:0]  idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic              idex_rw, idex_mr, exmem_rw, memwb_rw;
  logic [CNT_W-1:0]  stall_cnt;

  assign hazard = bus.IFID_valid & idex_mr & idex_rw & (idex_rd != '0) &
                  ((idex_rd == bus.IFID_rs) | (idex_rd == bus.IFID_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  // The first stall cycle is spent in RUN, so HOLD covers the remaining STALL_CYCLES-1.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    unique case (state)
      RUN: begin
        if (hazard && (STALL_CYCLES > 1)) begin
          state_next = HOLD;
          hold_next  = HOLD_W'(STALL_CYCLES - 1);
        end
      end
      HOLD: begin
        hold_next = hold_cnt - 1'b1;
        if (hold_cnt == HOLD_W'(1)) begin
          state_next = RUN;
          hold_next  = '0;
        end
      end
      default: begin
        state_next = RUN;
        hold_next  = '0;
      end
    endcase
  end

  always_comb begin
    stall         = (state == HOLD) | ((state == RUN) & hazard);
    bus.PCWrite   = ~stall;
    bus.IFIDWrite = ~stall;
    bus.IDEX_bubble = stall;
    bus.IFIDFlush = bus.branch_taken & bus.IFID_valid & ~stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_rs   <= '0;
      idex_rt   <= '0;
      idex_rd   <= '0;
      idex_rw   <= 1'b0;
      idex_mr   <= 1'b0;
      exmem_rd  <= '0;
      exmem_rw  <= 1'b0;
      memwb_rd  <= '0;
      memwb_rw  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall || !bus.IFID_valid) begin
        idex_rs <= '0;
        idex_rt <= '0;
        idex_rd <= '0;
        idex_rw <= 1'b0;
        idex_mr <= 1'b0;
      end else begin
        idex_rs <= bus.IFID_rs;
        idex_rt <= bus.IFID_rt;
        idex_rd <= bus.IFID_rd;
        idex_rw <= bus.IFID_RegWrite;
        idex_mr <= bus.IFID_MemRead;
      end
      exmem_rd <= idex_rd;
      exmem_rw <= idex_rw;
      memwb_rd <= exmem_rd;
      memwb_rw <= exmem_rw;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.IDEX_rs        = idex_rs;
  assign bus.IDEX_rt        = idex_rt;
  assign bus.IDEX_rd        = idex_rd;
  assign bus.IDEX_RegWrite  = idex_rw;
  assign bus.IDEX_MemRead   = idex_mr;
  assign bus.EXMEM_rd       = exmem_rd;
  assign bus.EXMEM_RegWrite = exmem_rw;
  assign bus.MEMWB_rd       = memwb_rd;
  assign bus.MEMWB_RegWrite = memwb_rw;
  assign bus.stall_count    = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Drives three configurations (STALL_CYCLES 1/3/5, the last with a 2-bit
// counter) with shared stimulus and compares each against a pipeline model.
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] t_rs = '0, t_rt = '0, t_rd = '0;
  logic       t_rw = 1'b0, t_mr = 1'b0, t_v = 1'b0, t_br = 1'b0;

  hazard_stall_unit_if #(.REG_W(2), .CNT_W(8)) b1 ();
  hazard_stall_unit_if #(.REG_W(2), .CNT_W(8)) b3 ();
  hazard_stall_unit_if #(.REG_W(2), .CNT_W(2)) bs ();

  assign b1.IFID_rs = t_rs, b1.IFID_rt = t_rt, b1.IFID_rd = t_rd, b1.IFID_RegWrite = t_rw,
         b1.IFID_MemRead = t_mr, b1.IFID_valid = t_v, b1.branch_taken = t_br;
  assign b3.IFID_rs = t_rs, b3.IFID_rt = t_rt, b3.IFID_rd = t_rd, b3.IFID_RegWrite = t_rw,
         b3.IFID_MemRead = t_mr, b3.IFID_valid = t_v, b3.branch_taken = t_br;
  assign bs.IFID_rs = t_rs, bs.IFID_rt = t_rt, bs.IFID_rd = t_rd, bs.IFID_RegWrite = t_rw,
         bs.IFID_MemRead = t_mr, bs.IFID_valid = t_v, bs.branch_taken = t_br;

  hazard_stall_unit #(.REG_W(2), .STALL_CYCLES(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  hazard_stall_unit #(.REG_W(2), .STALL_CYCLES(3), .CNT_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  hazard_stall_unit #(.REG_W(2), .STALL_CYCLES(5), .CNT_W(2)) us (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

  typedef struct packed {
    logic pcw, ifw, fl, bub;
    logic [1:0] irs, irt, ird;
    logic irw, imr;
    logic [1:0] erd;
    logic erw;
    logic [1:0] mrd;
    logic mrw;
    logic [7:0] cnt;
  } obs_t;

  obs_t obs [3];
  assign obs[0] = {b1.PCWrite, b1.IFIDWrite, b1.IFIDFlush, b1.IDEX_bubble, b1.IDEX_rs, b1.IDEX_rt,
                   b1.IDEX_rd, b1.IDEX_RegWrite, b1.IDEX_MemRead, b1.EXMEM_rd, b1.EXMEM_RegWrite,
                   b1.MEMWB_rd, b1.MEMWB_RegWrite, b1.stall_count};
  assign obs[1] = {b3.PCWrite, b3.IFIDWrite, b3.IFIDFlush, b3.IDEX_bubble, b3.IDEX_rs, b3.IDEX_rt,
                   b3.IDEX_rd, b3.IDEX_RegWrite, b3.IDEX_MemRead, b3.EXMEM_rd, b3.EXMEM_RegWrite,
                   b3.MEMWB_rd, b3.MEMWB_RegWrite, b3.stall_count};
  assign obs[2] = {bs.PCWrite, bs.IFIDWrite, bs.IFIDFlush, bs.IDEX_bubble, bs.IDEX_rs, bs.IDEX_rt,
                   bs.IDEX_rd, bs.IDEX_RegWrite, bs.IDEX_MemRead, bs.EXMEM_rd, bs.EXMEM_RegWrite,
                   bs.MEMWB_rd, bs.MEMWB_RegWrite, 6'b0, bs.stall_count};

  // Model: pipe[k][0..2] = ID/EX, EX/MEM, MEM/WB; rem = forced stall cycles still owed.
  typedef struct packed {logic [1:0] rs, rt, rd; logic rw, mr;} ent_t;
  ent_t pipe [3][3];
  int   rem [3];
  int   cnt [3];
  int   scyc [3] = '{1, 3, 5};
  int   cmax [3] = '{255, 255, 3};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic m_hazard(input int k);
    ent_t e = pipe[k][0];
    return t_v && e.mr && e.rw && (e.rd != 2'd0) && (e.rd == t_rs || e.rd == t_rt);
  endfunction

  function automatic logic m_stall(input int k);
    return (rem[k] > 0) || m_hazard(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      cnt[k] = 0;
      for (int s = 0; s < 3; s++) pipe[k][s] = '0;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 3; k++) begin
      logic st = m_stall(k);
      check($sformatf("u%0d.PCWrite", k), 32'(obs[k].pcw), 32'(!st));
      check($sformatf("u%0d.IFIDWrite", k), 32'(obs[k].ifw), 32'(!st));
      check($sformatf("u%0d.IDEX_bubble", k), 32'(obs[k].bub), 32'(st));
      check($sformatf("u%0d.IFIDFlush", k), 32'(obs[k].fl), 32'(t_br && t_v && !st));
      check($sformatf("u%0d.IDEX_rs", k), 32'(obs[k].irs), 32'(pipe[k][0].rs));
      check($sformatf("u%0d.IDEX_rt", k), 32'(obs[k].irt), 32'(pipe[k][0].rt));
      check($sformatf("u%0d.IDEX_rd", k), 32'(obs[k].ird), 32'(pipe[k][0].rd));
      check($sformatf("u%0d.IDEX_RegWrite", k), 32'(obs[k].irw), 32'(pipe[k][0].rw));
      check($sformatf("u%0d.IDEX_MemRead", k), 32'(obs[k].imr), 32'(pipe[k][0].mr));
      check($sformatf("u%0d.EXMEM_rd", k), 32'(obs[k].erd), 32'(pipe[k][1].rd));
      check($sformatf("u%0d.EXMEM_RegWrite", k), 32'(obs[k].erw), 32'(pipe[k][1].rw));
      check($sformatf("u%0d.MEMWB_rd", k), 32'(obs[k].mrd), 32'(pipe[k][2].rd));
      check($sformatf("u%0d.MEMWB_RegWrite", k), 32'(obs[k].mrw), 32'(pipe[k][2].rw));
      check($sformatf("u%0d.stall_count", k), 32'(obs[k].cnt), 32'(cnt[k]));
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic st = m_stall(k);
      logic hz = m_hazard(k);
      if (st && cnt[k] < cmax[k]) cnt[k]++;
      if (rem[k] > 0) rem[k]--;
      else if (hz) rem[k] = scyc[k] - 1;
      pipe[k][2] = pipe[k][1];
      pipe[k][1] = pipe[k][0];
      pipe[k][0] = (st || !t_v) ? ent_t'('0) : ent_t'({t_rs, t_rt, t_rd, t_rw, t_mr});
    end
  endtask

  // Called at posedge+1; inputs settle, outputs are checked before the next edge.
  task automatic drive(input logic [1:0] rs, rt, rd, input logic rw, mr, v, br);
    t_rs = rs; t_rt = rt; t_rd = rd; t_rw = rw; t_mr = mr; t_v = v; t_br = br;
    #2;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic nop();
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ns;
    do_reset();
    nop();
    check("reset.PCWrite", 32'(obs[0].pcw), 32'd1);
    check("reset.stall_count", 32'(obs[0].cnt), 32'd0);

    // basic load-use with a single bubble
    drive(2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check("basic.PCWrite", 32'(obs[0].pcw), 32'd0);
    check("basic.IFIDWrite", 32'(obs[0].ifw), 32'd0);
    check("basic.bubble", 32'(obs[0].bub), 32'd1);
    tick();
    drive(2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check("basic.release", 32'(obs[0].pcw), 32'd1);
    check("basic.bubble_rw", 32'(obs[0].irw), 32'd0);
    check("basic.bubble_rd", 32'(obs[0].ird), 32'd0);
    tick();
    nop();
    check("basic.add_rs", 32'(obs[0].irs), 32'd1);
    check("basic.count", 32'(obs[0].cnt), 32'd1);
    for (int i = 0; i < 8; i++) begin nop(); tick(); end

    // loads that must not stall
    do_reset();
    drive(2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("r0.no_stall", 32'(obs[1].pcw), 32'd1);
    tick();
    drive(2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(2'd1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mismatch_reg.no_stall", 32'(obs[1].pcw), 32'd1);
    tick();

    // three-cycle stall on u3, five cycles saturating a 2-bit counter on us
    do_reset();
    drive(2'd0, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      drive(2'd0, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      if (!obs[1].pcw) ns++;
      tick();
    end
    check("stall3.length", 32'(ns), 32'd3);
    nop();
    check("stall3.count", 32'(obs[1].cnt), 32'd3);
    check("sat.count", 32'(obs[2].cnt), 32'd3);
    tick();

    // branch arriving during a stall is deferred
    do_reset();
    drive(2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    check("branch.in_stall", 32'(obs[0].fl), 32'd0);
    tick();
    drive(2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    check("branch.after", 32'(obs[0].fl), 32'd1);
    check("branch.PCWrite", 32'(obs[0].pcw), 32'd1);
    tick();

    // shadow pipeline latency
    do_reset();
    drive(2'd1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    check("shadow.IDEX_rd", 32'(obs[0].ird), 32'd2);
    nop(); tick();
    check("shadow.EXMEM_rd", 32'(obs[0].erd), 32'd2);
    nop(); tick();
    check("shadow.MEMWB_rd", 32'(obs[0].mrd), 32'd2);
    check("shadow.MEMWB_RegWrite", 32'(obs[0].mrw), 32'd1);

    // asynchronous reset in the middle of HOLD
    do_reset();
    drive(2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(2'd1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(2'd1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    check("hold.active", 32'(obs[1].pcw), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.PCWrite", 32'(obs[1].pcw), 32'd1);
    check("rst.bubble", 32'(obs[1].bub), 32'd0);
    check("rst.count", 32'(obs[1].cnt), 32'd0);
    model_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 4),
            1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 2));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
